// File: rtl/fir_pkg.sv
// Shared constants, state codes and the address-width helper
// for the FIR multiply-accumulate scheduler.
package fir_pkg;

   localparam int TAPS   = 100;
   localparam int DATA_W = 16;
   localparam int ACC_W  = 40;

   function automatic int addr_w(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w++;
      return w;
   endfunction

   typedef logic [1:0] state_t;

   localparam state_t S_IDLE  = 2'd0;
   localparam state_t S_MAC   = 2'd1;
   localparam state_t S_DRAIN = 2'd2;
   localparam state_t S_OUT   = 2'd3;

endpackage

// File: rtl/fir_mac_scheduler_if.sv
// Sample-in / result-out valid-ready streams
// of the FIR MAC scheduler.
interface fir_mac_scheduler_if #(
   parameter int DATA_W = fir_pkg::DATA_W,
   parameter int ACC_W  = fir_pkg::ACC_W
);

   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_ready;
   logic              out_valid;
   logic [ACC_W-1:0]  out_data;
   logic              out_ready;

   modport master (
      output in_valid,
      output in_data,
      input  in_ready,
      input  out_valid,
      input  out_data,
      output out_ready
   );

   modport slave (
      input  in_valid,
      input  in_data,
      output in_ready,
      output out_valid,
      output out_data,
      input  out_ready
   );

endinterface

// File: rtl/fir_sample_ring.sv
// Sample history ring: one write port, one registered
// read port, whole array cleared by synchronous reset.
module fir_sample_ring #(
   parameter int DEPTH  = fir_pkg::TAPS,
   parameter int DATA_W = fir_pkg::DATA_W,
   parameter int AW     = fir_pkg::addr_w(fir_pkg::TAPS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en_i,
   input  logic [AW-1:0]     wr_addr_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic              rd_en_i,
   input  logic [AW-1:0]     rd_addr_i,
   output logic [DATA_W-1:0] rd_data_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rd_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         rd_q <= '0;
      end else begin
         if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
         end
         if (rd_en_i) begin
            rd_q <= mem_q[rd_addr_i];
         end
      end
   end

   assign rd_data_o = rd_q;

endmodule

// File: rtl/fir_mac_scheduler.sv
// Time-multiplexed FIR: one shared external multiplier,
// one tap per cycle, result handed out on a valid/ready stream.
module fir_mac_scheduler #(
   parameter int  TAPS   = fir_pkg::TAPS,
   parameter int  DATA_W = fir_pkg::DATA_W,
   parameter int  ACC_W  = fir_pkg::ACC_W,
   localparam int AW     = fir_pkg::addr_w(TAPS)
) (
   input  logic                clk,
   input  logic                rst,
   fir_mac_scheduler_if.slave  bus,
   output logic [AW-1:0]       coef_addr,
   input  logic [DATA_W-1:0]   coef_data,
   output logic [DATA_W-1:0]   mult_a,
   output logic [DATA_W-1:0]   mult_b,
   input  logic [2*DATA_W-1:0] mult_p,
   output logic                busy
);

   import fir_pkg::*;

   localparam logic [AW-1:0] LAST = AW'(TAPS - 1);
   localparam int            EXT  = ACC_W - 2 * DATA_W;

   state_t              state_q, state_d;
   logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]       rp_q, rp_d;
   logic [AW-1:0]       k_q, k_d;
   logic                drn_q, drn_d;
   logic [ACC_W-1:0]    acc_q, acc_d;
   logic                v1_q, v2_q;
   logic [2*DATA_W-1:0] prod_q;
   logic [DATA_W-1:0]   smp;
   logic                accept;

   assign accept = (state_q == S_IDLE) && bus.in_valid;

   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      rp_d     = rp_q;
      k_d      = k_q;
      drn_d    = drn_q;
      unique case (state_q)
         S_IDLE: begin
            if (bus.in_valid) begin
               state_d = S_MAC;
               k_d     = '0;
               rp_d    = wr_ptr_q;
            end
         end
         S_MAC: begin
            rp_d = (rp_q == '0) ? LAST : rp_q - AW'(1);
            if (k_q == LAST) begin
               k_d     = '0;
               drn_d   = 1'b0;
               state_d = S_DRAIN;
            end else begin
               k_d = k_q + AW'(1);
            end
         end
         // Two cycles let the last product reach the accumulator.
         S_DRAIN: begin
            drn_d = 1'b1;
            if (drn_q) state_d = S_OUT;
         end
         S_OUT: begin
            if (bus.out_ready) begin
               state_d  = S_IDLE;
               wr_ptr_d = (wr_ptr_q == LAST) ? '0
                                             : wr_ptr_q + AW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      acc_d = acc_q;
      if (accept) begin
         acc_d = '0;
      end else if (v2_q) begin
         acc_d = acc_q + {{EXT{prod_q[2*DATA_W-1]}}, prod_q};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         wr_ptr_q <= '0;
         rp_q     <= '0;
         k_q      <= '0;
         drn_q    <= 1'b0;
         acc_q    <= '0;
         v1_q     <= 1'b0;
         v2_q     <= 1'b0;
         prod_q   <= '0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rp_q     <= rp_d;
         k_q      <= k_d;
         drn_q    <= drn_d;
         acc_q    <= acc_d;
         v1_q     <= (state_q == S_MAC);
         v2_q     <= v1_q;
         prod_q   <= v1_q ? mult_p : '0;
      end
   end

   fir_sample_ring #(
      .DEPTH  (TAPS),
      .DATA_W (DATA_W),
      .AW     (AW)
   ) u_ring (
      .clk       (clk),
      .rst       (rst),
      .wr_en_i   (accept),
      .wr_addr_i (wr_ptr_q),
      .wr_data_i (bus.in_data),
      .rd_en_i   (state_q == S_MAC),
      .rd_addr_i (rp_q),
      .rd_data_o (smp)
   );

   assign coef_addr     = k_q;
   assign mult_a        = v1_q ? smp : '0;
   assign mult_b        = v1_q ? coef_data : '0;
   assign busy          = (state_q != S_IDLE);
   assign bus.in_ready  = (state_q == S_IDLE);
   assign bus.out_valid = (state_q == S_OUT);
   assign bus.out_data  = acc_q;

endmodule
